// File: rtl/addrdec_pkg.sv
// Shared types and constants for the bus address decoder.
//   state_t  : access sequencer states
//   region_t : decoded target region of an address
//   PAGE_BITS, SIMIF_ADDR : page index width and the simulator-interface address
package addrdec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MEM,
        REG_IO,
        REG_SIMIF
    } region_t;

    localparam int unsigned PAGE_BITS  = 4;
    localparam logic [15:0] SIMIF_ADDR = 16'hFFFF;

endpackage

// File: rtl/addrdec_map.sv
// Combinational address map: classifies an address into a region and,
// for I/O, produces the one-hot I/O select vector.
//   addr_q : address to classify
//   region : REG_NONE / REG_MEM / REG_IO / REG_SIMIF
//   io_sel : one-hot I/O select (page 15 -> bit 0), zero unless region is REG_IO
module addrdec_map
    import addrdec_pkg::*;
#(
    parameter int unsigned MEM_ADDR_SIZE = 32,
    parameter int unsigned MEM_PAGES     = 4,
    parameter int unsigned NR_IO         = 4
) (
    input  logic [MEM_ADDR_SIZE-1:0] addr_q,
    output region_t                  region,
    output logic [NR_IO-1:0]         io_sel
);

    // Page masks over the 16 one-hot page lines: memory occupies the low
    // pages, I/O the top NR_IO pages.
    localparam logic [15:0] MEM_MASK = 16'((32'd1 << MEM_PAGES) - 32'd1);
    localparam logic [15:0] IO_MASK  = 16'(~((32'd1 << (16 - NR_IO)) - 32'd1));

    logic [PAGE_BITS-1:0] page;
    logic [15:0]          page_oh;
    logic [NR_IO-1:0]     io_hit;
    logic                 in_range;
    logic                 mem_page;
    logic                 io_page;

    assign page     = addr_q[15:12];
    assign in_range = (addr_q[MEM_ADDR_SIZE-1:16] == '0);

    decoder #(
        .ADDR_SIZE(PAGE_BITS)
    ) u_page_dec (
        .addr(page),
        .sel (page_oh)
    );

    assign mem_page = |(page_oh & MEM_MASK);
    assign io_page  = |(page_oh & IO_MASK);

    // I/O select numbering runs downward from page 15.
    for (genvar g = 0; g < NR_IO; g++) begin : g_io
        assign io_hit[g] = page_oh[15-g];
    end

    always_comb begin
        region = REG_NONE;
        io_sel = '0;
        if (in_range) begin
            if (addr_q[15:0] == SIMIF_ADDR) begin
                region = REG_SIMIF;
            end else if (mem_page) begin
                region = REG_MEM;
            end else if (io_page) begin
                region = REG_IO;
                io_sel = io_hit;
            end
        end
    end

endmodule

// File: rtl/decoder.sv
// Generic binary to one-hot decoder.
//   addr : ADDR_SIZE-bit binary index
//   sel  : 2**ADDR_SIZE one-hot output, bit addr set
module decoder #(
    parameter int unsigned ADDR_SIZE = 4
) (
    input  logic [ADDR_SIZE-1:0]      addr,
    output logic [(1<<ADDR_SIZE)-1:0] sel
);

    always_comb begin
        sel       = '0;
        sel[addr] = 1'b1;
    end

endmodule

// File: rtl/addrdec2.sv
// Parametrised bus address decoder with access sequencing.
// Latches the request address, asserts one chip select for the access,
// inserts per-region wait states, honours slave_wait, and terminates each
// access with exactly one ack or err (unmapped address or timeout).
//   clk, reset    : clock, asynchronous active-high reset
//   addr, req     : request address and strobe
//   slave_wait    : selected slave extends the access
//   err_clr       : clears the sticky error flag
//   cs_mem, cs_io, cs_simif : chip selects, high only in ACCESS
//   ack, err      : single-cycle access termination
//   busy          : sequencer not idle
//   err_valid, err_addr : sticky error flag and last faulting address
module addrdec2
    import addrdec_pkg::*;
#(
    parameter int unsigned MEM_ADDR_SIZE = 32,
    parameter int unsigned MEM_PAGES     = 4,
    parameter int unsigned NR_IO         = 4,
    parameter int unsigned MEM_WS        = 0,
    parameter int unsigned IO_WS         = 1,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [MEM_ADDR_SIZE-1:0] addr,
    input  logic                     req,
    input  logic                     slave_wait,
    input  logic                     err_clr,
    output logic                     cs_mem,
    output logic [NR_IO-1:0]         cs_io,
    output logic                     cs_simif,
    output logic                     ack,
    output logic                     err,
    output logic                     busy,
    output logic                     err_valid,
    output logic [MEM_ADDR_SIZE-1:0] err_addr
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MEM_WS_C = CW'(MEM_WS);
    localparam logic [CW-1:0] IO_WS_C  = CW'(IO_WS);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    if (MEM_ADDR_SIZE < 17) begin : g_bad_aw
        $error("addrdec2: MEM_ADDR_SIZE must be at least 17");
    end
    if (NR_IO < 1 || MEM_PAGES + NR_IO > 16) begin : g_bad_map
        $error("addrdec2: need NR_IO >= 1 and MEM_PAGES + NR_IO <= 16");
    end
    if (TIMEOUT <= MEM_WS || TIMEOUT <= IO_WS) begin : g_bad_to
        $error("addrdec2: TIMEOUT must exceed MEM_WS and IO_WS");
    end

    state_t                   state;
    logic [MEM_ADDR_SIZE-1:0] addr_q;
    logic [MEM_ADDR_SIZE-1:0] dec_addr;
    logic [CW-1:0]            ws_cnt;
    logic [CW-1:0]            to_cnt;
    region_t                  region;
    logic [NR_IO-1:0]         io_sel;
    logic                     in_access;

    // One decoder serves both phases: in IDLE it classifies the incoming
    // address to choose ACCESS or ERR; afterwards it decodes the latched
    // address that drives the selects. Selects are gated off in IDLE.
    assign dec_addr = (state == IDLE) ? addr : addr_q;

    addrdec_map #(
        .MEM_ADDR_SIZE(MEM_ADDR_SIZE),
        .MEM_PAGES    (MEM_PAGES),
        .NR_IO        (NR_IO)
    ) u_map (
        .addr_q(dec_addr),
        .region(region),
        .io_sel(io_sel)
    );

    assign in_access = (state == ACCESS);
    assign cs_mem    = in_access && (region == REG_MEM);
    assign cs_simif  = in_access && (region == REG_SIMIF);
    assign cs_io     = (in_access && (region == REG_IO)) ? io_sel : '0;
    assign ack       = in_access && (ws_cnt == '0) && !slave_wait;
    assign err       = (state == ERR);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            ws_cnt    <= '0;
            to_cnt    <= '0;
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else begin
            // Later ERR-state assignment overrides a coincident clear.
            if (err_clr) begin
                err_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= addr;
                        to_cnt <= '0;
                        case (region)
                            REG_MEM: begin
                                ws_cnt <= MEM_WS_C;
                                state  <= ACCESS;
                            end
                            REG_IO, REG_SIMIF: begin
                                ws_cnt <= IO_WS_C;
                                state  <= ACCESS;
                            end
                            default: begin
                                state <= ERR;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    if (ws_cnt != '0) begin
                        ws_cnt <= ws_cnt - 1'b1;
                    end
                    to_cnt <= to_cnt + 1'b1;
                    if (ack) begin
                        state <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        state <= ERR;
                    end
                end
                ERR: begin
                    err_addr  <= addr_q;
                    err_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addrdec2.sv
// Self-checking bench for addrdec2 with default parameters: table-driven
// accesses plus hand-written sequences for reset and error-flag corners.
module tb_addrdec2;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        req;
    logic        slave_wait;
    logic        err_clr;
    logic        cs_mem;
    logic [3:0]  cs_io;
    logic        cs_simif;
    logic        ack;
    logic        err;
    logic        busy;
    logic        err_valid;
    logic [31:0] err_addr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    addrdec2 #(
        .MEM_ADDR_SIZE(32),
        .MEM_PAGES    (4),
        .NR_IO        (4),
        .MEM_WS       (0),
        .IO_WS        (1),
        .TIMEOUT      (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .req       (req),
        .slave_wait(slave_wait),
        .err_clr   (err_clr),
        .cs_mem    (cs_mem),
        .cs_io     (cs_io),
        .cs_simif  (cs_simif),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .err_valid (err_valid),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned hold;   // cycles of slave_wait from the first access cycle
        logic        emem;
        logic [3:0]  eio;
        logic        esimif;
        logic        eack;   // 1: ack expected, 0: err expected
        int unsigned elat;   // termination cycle, counted from k+1 = 1
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request from the sample point after an edge and follows it
    // to termination. Selects must match the expected pattern in every
    // cycle before termination, and in the termination cycle only for ack.
    task automatic run_access(input vec_t v, input logic clr_at_term);
        int unsigned n;
        logic        done;
        logic        got_ack;
        logic        seq_ok;
        logic        exp_on;
        n       = 0;
        done    = 1'b0;
        got_ack = 1'b0;
        seq_ok  = 1'b1;
        req     = 1'b1;
        addr    = v.addr;
        @(posedge clk);
        #2;
        req = 1'b0;
        while (!done && n < 40) begin
            n++;
            slave_wait = (n <= v.hold);
            err_clr    = clr_at_term && (n == v.elat);
            #1;
            exp_on = (n < v.elat) || (n == v.elat && v.eack);
            if ({cs_mem, cs_io, cs_simif} !== (exp_on ? {v.emem, v.eio, v.esimif} : 6'b0))
                seq_ok = 1'b0;
            if (busy !== 1'b1) seq_ok = 1'b0;
            if (ack === 1'b1 && err === 1'b1) seq_ok = 1'b0;
            if (ack === 1'b1 || err === 1'b1) begin
                done    = 1'b1;
                got_ack = ack;
            end
            @(posedge clk);
            #2;
        end
        slave_wait = 1'b0;
        err_clr    = 1'b0;
        chk($sformatf("terminated@%08h", v.addr), 64'(done), 64'(1'b1));
        chk($sformatf("latency@%08h", v.addr), 64'(n), 64'(v.elat));
        chk($sformatf("ack_vs_err@%08h", v.addr), 64'(got_ack), 64'(v.eack));
        chk($sformatf("selects_busy@%08h", v.addr), 64'(seq_ok), 64'(1'b1));
        #1;
        chk($sformatf("idle_after@%08h", v.addr), 64'({busy, cs_mem, cs_io, cs_simif, ack, err}), 64'(0));
        if (!v.eack) begin
            chk($sformatf("err_valid@%08h", v.addr), 64'(err_valid), 64'(1'b1));
            chk($sformatf("err_addr@%08h", v.addr), 64'(err_addr), 64'(v.addr));
        end
    endtask

    vec_t vt[$];
    vec_t v;

    initial begin
        reset      = 1'b1;
        addr       = '0;
        req        = 1'b0;
        slave_wait = 1'b0;
        err_clr    = 1'b0;

        //        addr          hold mem   io       simif ack   lat
        vt.push_back('{32'h0000_1234, 0,  1'b1, 4'b0000, 1'b0, 1'b1, 1});
        vt.push_back('{32'h0000_3FFF, 0,  1'b1, 4'b0000, 1'b0, 1'b1, 1});
        vt.push_back('{32'h0000_0000, 0,  1'b1, 4'b0000, 1'b0, 1'b1, 1});
        vt.push_back('{32'h0000_F010, 0,  1'b0, 4'b0001, 1'b0, 1'b1, 2});
        vt.push_back('{32'h0000_FFFF, 0,  1'b0, 4'b0000, 1'b1, 1'b1, 2});
        vt.push_back('{32'h0000_FFFE, 0,  1'b0, 4'b0001, 1'b0, 1'b1, 2});
        vt.push_back('{32'h0000_E000, 0,  1'b0, 4'b0010, 1'b0, 1'b1, 2});
        vt.push_back('{32'h0000_D123, 0,  1'b0, 4'b0100, 1'b0, 1'b1, 2});
        vt.push_back('{32'h0000_C000, 0,  1'b0, 4'b1000, 1'b0, 1'b1, 2});
        vt.push_back('{32'h0000_4000, 0,  1'b0, 4'b0000, 1'b0, 1'b0, 1});
        vt.push_back('{32'h0000_BFFF, 0,  1'b0, 4'b0000, 1'b0, 1'b0, 1});
        vt.push_back('{32'h0000_8000, 0,  1'b0, 4'b0000, 1'b0, 1'b0, 1});
        vt.push_back('{32'h0001_0000, 0,  1'b0, 4'b0000, 1'b0, 1'b0, 1});
        vt.push_back('{32'h0001_FFFF, 0,  1'b0, 4'b0000, 1'b0, 1'b0, 1});
        vt.push_back('{32'h8000_1234, 0,  1'b0, 4'b0000, 1'b0, 1'b0, 1});
        vt.push_back('{32'h0000_0100, 3,  1'b1, 4'b0000, 1'b0, 1'b1, 4});
        vt.push_back('{32'h0000_F800, 1,  1'b0, 4'b0001, 1'b0, 1'b1, 2});
        vt.push_back('{32'h0000_F800, 2,  1'b0, 4'b0001, 1'b0, 1'b1, 3});
        vt.push_back('{32'h0000_FFFF, 5,  1'b0, 4'b0000, 1'b1, 1'b1, 6});
        vt.push_back('{32'h0000_2000, 14, 1'b1, 4'b0000, 1'b0, 1'b1, 15});
        vt.push_back('{32'h0000_2000, 15, 1'b1, 4'b0000, 1'b0, 1'b0, 16});
        vt.push_back('{32'h0000_C000, 99, 1'b0, 4'b1000, 1'b0, 1'b0, 16});

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("reset_outputs", 64'({cs_mem, cs_io, cs_simif, ack, err, busy, err_valid}), 64'(0));
        chk("reset_err_addr", 64'(err_addr), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #2;

        for (int i = 0; i < vt.size(); i++) begin
            run_access(vt[i], 1'b0);
        end

        // err_clr in the same cycle as a new error: the error wins.
        v = '{32'h0000_9000, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 1};
        run_access(v, 1'b1);

        // err_clr alone clears the flag but keeps the address.
        err_clr = 1'b1;
        @(posedge clk);
        #2;
        err_clr = 1'b0;
        #1;
        chk("err_clr_valid", 64'(err_valid), 64'(0));
        chk("err_clr_addr_kept", 64'(err_addr), 64'(32'h0000_9000));

        // A successful access leaves the cleared flag alone.
        v = '{32'h0000_1000, 0, 1'b1, 4'b0000, 1'b0, 1'b1, 1};
        run_access(v, 1'b0);
        chk("err_valid_stays_clear", 64'(err_valid), 64'(0));

        // Fresh error so the async reset has state to clear.
        v = '{32'h0000_A000, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 1};
        run_access(v, 1'b0);

        // Reset in the middle of an I/O wait state.
        req  = 1'b1;
        addr = 32'h0000_F010;
        @(posedge clk);
        #2;
        req = 1'b0;
        #1;
        chk("pre_reset_cs_io", 64'({cs_io, busy, ack}), 64'({4'b0001, 1'b1, 1'b0}));
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({cs_mem, cs_io, cs_simif, ack, err, busy, err_valid}), 64'(0));
        chk("async_reset_err_addr", 64'(err_addr), 64'(0));
        @(posedge clk);
        #2;
        chk("held_reset_no_term", 64'({ack, err, busy}), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #2;
        v = '{32'h0000_0000, 0, 1'b1, 4'b0000, 1'b0, 1'b1, 1};
        run_access(v, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1, "global timeout");
    end

endmodule
